// File: rtl/dtmr_pkg.sv
// Shared definitions for the motor PWM driver: FSM encoding, PWM period, direction bit index
// and the 2-of-3 fault vote.
package dtmr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int PWM_PERIOD = 15;
  localparam int DIR_BIT    = 3;

  function automatic logic fault_majority(input logic [2:0] f);
    return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler; tick_o strobes for one clk every PRESCALE clks.
module pwm_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick_o = (pre_q == PW'(PRESCALE - 1));
    pre_d  = tick_o ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/motor_pwm_drv.sv
// H-bridge PWM driver with period-aligned command sampling and dead-time on reversal.
// Optional latched fault stop enabled by defining DTMR_FAULT_STOP_EN.
module motor_pwm_drv
  import dtmr_pkg::*;
#(
  parameter int PRESCALE   = 4,
  parameter int DEAD_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] speed_cmd_i,
  input  logic [3:0] dir_cmd_i,
  input  logic [2:0] fault_i,
  input  logic       fault_clr_i,
  output logic       pwm_fwd_o,
  output logic       pwm_rev_o,
  output logic       busy_o,
  output logic       stop_o
);

  logic       tick;
  logic       period_start;
  logic       drive_on;
  logic       dir_req;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] spd_q, spd_d;
  logic       dir_sh_q, dir_sh_d;
  logic       dir_q, dir_d;
  logic [3:0] dead_q, dead_d;
  logic       fwd_q, fwd_d;
  logic       rev_q, rev_d;
  logic       busy_q, busy_d;
  logic       stop_q, stop_d;
  logic       unused_dir;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign dir_req      = dir_cmd_i[DIR_BIT];
  assign unused_dir   = ^dir_cmd_i[2:0];
  assign period_start = tick && (cnt_q == 4'(PWM_PERIOD - 1));

`ifndef DTMR_FAULT_STOP_EN
  logic unused_fault;
  assign unused_fault = ^{fault_i, fault_clr_i};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    spd_d    = spd_q;
    dir_sh_d = dir_sh_q;
    dir_d    = dir_q;
    dead_d   = dead_q;

    if (tick) begin
      case (state_q)
        ST_IDLE, ST_DRIVE: begin
          cnt_d = period_start ? 4'd0 : cnt_q + 4'd1;
          if (period_start) begin
            spd_d    = speed_cmd_i;
            dir_sh_d = dir_req;
            if (speed_cmd_i == 4'd0) begin
              state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
              state_d = ST_DRIVE;
              dir_d   = dir_req;
            end else if (dir_req != dir_q) begin
              state_d = ST_DEAD;
              dead_d  = 4'd0;
            end
          end
        end
        // Counter is frozen in DEAD so no period start can resample the direction.
        ST_DEAD: begin
          if (dead_q == 4'(DEAD_TICKS - 1)) begin
            state_d = ST_DRIVE;
            dir_d   = dir_sh_q;
            cnt_d   = 4'd0;
          end else begin
            dead_d = dead_q + 4'd1;
          end
        end
        default: ;
      endcase
    end

`ifdef DTMR_FAULT_STOP_EN
    if (fault_majority(fault_i)) begin
      state_d = ST_FAULT;
      cnt_d   = 4'd0;
      dead_d  = 4'd0;
    end else if ((state_q == ST_FAULT) && fault_clr_i) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end
`endif

    // Legs derive from one direction bit, so they can never both be high.
    drive_on = (state_d == ST_DRIVE) && (cnt_d < spd_d);
    fwd_d    = drive_on && !dir_d;
    rev_d    = drive_on && dir_d;
    busy_d   = (state_d == ST_DEAD);
    stop_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      spd_q    <= 4'd0;
      dir_sh_q <= 1'b0;
      dir_q    <= 1'b0;
      dead_q   <= 4'd0;
      fwd_q    <= 1'b0;
      rev_q    <= 1'b0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      spd_q    <= spd_d;
      dir_sh_q <= dir_sh_d;
      dir_q    <= dir_d;
      dead_q   <= dead_d;
      fwd_q    <= fwd_d;
      rev_q    <= rev_d;
      busy_q   <= busy_d;
      stop_q   <= stop_d;
    end
  end

  assign pwm_fwd_o = fwd_q;
  assign pwm_rev_o = rev_q;
  assign busy_o    = busy_q;
  assign stop_o    = stop_q;

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Directed self-checking bench for motor_pwm_drv (PRESCALE=1, DEAD_TICKS=3).
module tb_motor_pwm_drv;
  import dtmr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] speed_cmd = 4'd0;
  logic [3:0] dir_cmd = 4'd0;
  logic [2:0] fault = 3'd0;
  logic       fault_clr = 1'b0;
  logic       pwm_fwd_o, pwm_rev_o, busy_o, stop_o;

  int checks = 0;
  int failures = 0;

  motor_pwm_drv #(.PRESCALE(1), .DEAD_TICKS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .speed_cmd_i (speed_cmd),
    .dir_cmd_i   (dir_cmd),
    .fault_i     (fault),
    .fault_clr_i (fault_clr),
    .pwm_fwd_o   (pwm_fwd_o),
    .pwm_rev_o   (pwm_rev_o),
    .busy_o      (busy_o),
    .stop_o      (stop_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the design 14 edges away from its first period start once step(14) is applied.
  task automatic do_reset();
    rst_n = 1'b0;
    speed_cmd = 4'd0;
    dir_cmd = 4'd0;
    fault = 3'd0;
    fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_period(output int hf, output int hr, output int ov, output logic first_f);
    hf = 0;
    hr = 0;
    ov = 0;
    first_f = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (i == 0) first_f = pwm_fwd_o;
      hf += int'(pwm_fwd_o);
      hr += int'(pwm_rev_o);
      if (pwm_fwd_o && pwm_rev_o) ov++;
    end
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o, stop_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000", {pwm_fwd_o, pwm_rev_o, busy_o, stop_o});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", dut.state_q, ST_IDLE);
    end
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o, stop_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle_outputs got=%b want=0000", {pwm_fwd_o, pwm_rev_o, busy_o, stop_o});
    end
  endtask

  task automatic test_duty_fwd();
    int hf, hr, ov;
    logic ff;
    do_reset();
    speed_cmd = 4'd5;
    dir_cmd = 4'd0;
    step(14);
    checks++;
    if (pwm_fwd_o !== 1'b0) begin
      failures++;
      $display("FAIL duty5_before_start got=%b want=0", pwm_fwd_o);
    end
    run_period(hf, hr, ov, ff);
    checks++;
    if (ff !== 1'b1) begin
      failures++;
      $display("FAIL duty5_first_edge got=%b want=1", ff);
    end
    checks++;
    if (hf != 5 || hr != 0) begin
      failures++;
      $display("FAIL duty5_period1 fwd=%0d rev=%0d want fwd=5 rev=0", hf, hr);
    end
    run_period(hf, hr, ov, ff);
    checks++;
    if (hf != 5 || hr != 0) begin
      failures++;
      $display("FAIL duty5_period2 fwd=%0d rev=%0d want fwd=5 rev=0", hf, hr);
    end
  endtask

  task automatic test_full_zero();
    int hf, hr, ov, tot;
    logic ff;
    do_reset();
    speed_cmd = 4'd15;
    step(14);
    run_period(hf, hr, ov, ff);
    tot = hf;
    run_period(hf, hr, ov, ff);
    tot += hf;
    checks++;
    if (tot != 30) begin
      failures++;
      $display("FAIL duty15_continuous high=%0d want=30", tot);
    end
    speed_cmd = 4'd0;
    run_period(hf, hr, ov, ff);
    checks++;
    if (hf != 0 || hr != 0) begin
      failures++;
      $display("FAIL duty0_legs fwd=%0d rev=%0d want 0 0", hf, hr);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL duty0_state got=%0d want=%0d", dut.state_q, ST_IDLE);
    end
  endtask

  task automatic test_reversal();
    int hf, hr, ov, busy_n, low_n;
    logic ff, got;
    do_reset();
    speed_cmd = 4'd15;
    dir_cmd = 4'd0;
    step(14);
    run_period(hf, hr, ov, ff);
    dir_cmd = 4'b1000;
    busy_n = 0;
    low_n = 0;
    ov = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1);
      if (pwm_fwd_o && pwm_rev_o) ov++;
      if (pwm_rev_o) got = 1'b1;
      else begin
        if (busy_o) busy_n++;
        if (!pwm_fwd_o) low_n++;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rev_timeout got=no_rev want=rev_within_40");
    end
    checks++;
    if (busy_n != 3 || low_n != 3) begin
      failures++;
      $display("FAIL rev_deadtime busy=%0d low=%0d want 3 3", busy_n, low_n);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rev_busy_clear got=%b want=0", busy_o);
    end
    hr = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      hr += int'(pwm_rev_o);
      if (pwm_fwd_o && pwm_rev_o) ov++;
    end
    checks++;
    if (hr != 14 || ov != 0) begin
      failures++;
      $display("FAIL rev_drive high=%0d overlap=%0d want 14 0", hr, ov);
    end
  endtask

  // Continues from test_reversal: reverse drive, one edge before a period start.
  task automatic test_revert();
    dir_cmd = 4'b0000;
    step(1);
    checks++;
    if (busy_o !== 1'b1 || pwm_rev_o !== 1'b0) begin
      failures++;
      $display("FAIL revert_enter busy=%b rev=%b want 1 0", busy_o, pwm_rev_o);
    end
    dir_cmd = 4'b1000;
    step(2);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL revert_dead_held got=%b want=1", busy_o);
    end
    step(1);
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o} !== 3'b100) begin
      failures++;
      $display("FAIL revert_adopt got=%b want=100", {pwm_fwd_o, pwm_rev_o, busy_o});
    end
    step(15);
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o} !== 3'b001) begin
      failures++;
      $display("FAIL revert_reeval got=%b want=001", {pwm_fwd_o, pwm_rev_o, busy_o});
    end
  endtask

  task automatic test_mid_period();
    int hf, hr, ov;
    logic ff;
    do_reset();
    speed_cmd = 4'd3;
    step(14);
    hf = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) speed_cmd = 4'd10;
      step(1);
      hf += int'(pwm_fwd_o);
    end
    checks++;
    if (hf != 3) begin
      failures++;
      $display("FAIL midchange_current high=%0d want=3", hf);
    end
    run_period(hf, hr, ov, ff);
    checks++;
    if (hf != 10) begin
      failures++;
      $display("FAIL midchange_next high=%0d want=10", hf);
    end
  endtask

  task automatic test_fault();
    int hf, hr, ov;
    logic ff;
    do_reset();
    speed_cmd = 4'd15;
    step(14);
    run_period(hf, hr, ov, ff);
`ifdef DTMR_FAULT_STOP_EN
    fault = 3'b100;
    step(1);
    checks++;
    if (stop_o !== 1'b0 || pwm_fwd_o !== 1'b1) begin
      failures++;
      $display("FAIL fault_single stop=%b fwd=%b want 0 1", stop_o, pwm_fwd_o);
    end
    fault = 3'b110;
    step(1);
    checks++;
    if ({stop_o, pwm_fwd_o, pwm_rev_o} !== 3'b100) begin
      failures++;
      $display("FAIL fault_enter got=%b want=100", {stop_o, pwm_fwd_o, pwm_rev_o});
    end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    step(1);
    checks++;
    if (stop_o !== 1'b1) begin
      failures++;
      $display("FAIL fault_clr_blocked got=%b want=1", stop_o);
    end
    fault = 3'b000;
    step(2);
    checks++;
    if (stop_o !== 1'b1) begin
      failures++;
      $display("FAIL fault_latched got=%b want=1", stop_o);
    end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    checks++;
    if (stop_o !== 1'b0 || dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL fault_exit stop=%b state=%0d want 0 %0d", stop_o, dut.state_q, ST_IDLE);
    end
`else
    fault = 3'b111;
    fault_clr = 1'b1;
    step(3);
    checks++;
    if (stop_o !== 1'b0 || pwm_fwd_o !== 1'b1) begin
      failures++;
      $display("FAIL fault_ignored stop=%b fwd=%b want 0 1", stop_o, pwm_fwd_o);
    end
    fault = 3'b000;
    fault_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_dead();
    int hf, hr, ov;
    logic ff;
    do_reset();
    speed_cmd = 4'd15;
    dir_cmd = 4'd0;
    step(14);
    run_period(hf, hr, ov, ff);
    dir_cmd = 4'b1000;
    step(1);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL rstdead_in_dead got=%b want=1", busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o, stop_o} !== 4'b0000) begin
      failures++;
      $display("FAIL rstdead_async got=%b want=0000", {pwm_fwd_o, pwm_rev_o, busy_o, stop_o});
    end
    @(posedge clk);
    #1;
    speed_cmd = 4'd0;
    rst_n = 1'b1;
    step(3);
    checks++;
    if (dut.state_q !== ST_IDLE || dut.dir_q !== 1'b0) begin
      failures++;
      $display("FAIL rstdead_restart state=%0d dir=%b want %0d 0", dut.state_q, dut.dir_q, ST_IDLE);
    end
    checks++;
    if ({pwm_fwd_o, pwm_rev_o, busy_o, stop_o} !== 4'b0000) begin
      failures++;
      $display("FAIL rstdead_outputs got=%b want=0000", {pwm_fwd_o, pwm_rev_o, busy_o, stop_o});
    end
  endtask

  initial begin
    test_reset();
    test_duty_fwd();
    test_full_zero();
    test_reversal();
    test_revert();
    test_mid_period();
    test_fault();
    test_reset_mid_dead();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
